// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the carry-lookahead adder.
//   GROUP_W      width of one lookahead group (4 bits)
//   grp_vec_t    one group's worth of propagate/generate/carry bits
//   grp_pg_t     group-level generate (gg) / propagate (gp) pair
//   grp_terms()  computes gg/gp of a 4-bit group from its per-bit p/g
// Optional feature macro used by the adder: CLA_OVF_EN (adds an ovf output).
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef logic [GROUP_W-1:0] grp_vec_t;

    typedef struct packed {
        logic gg;
        logic gp;
    } grp_pg_t;

    // Group generate is fully expanded so it does not depend on the group's
    // internal carries; group propagate is the AND of all bit propagates.
    function automatic grp_pg_t grp_terms(input grp_vec_t p, input grp_vec_t g);
        grp_pg_t r;
        r.gp = &p;
        r.gg = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// -----------------------------------------------------------------------------
// cla_group4
// Combinational 4-bit carry-lookahead group. Every internal carry is expanded
// directly from the group's p/g and its carry-in, so there is no ripple path
// inside the group.
// Ports:
//   p   in  4  per-bit propagate (a ^ b)
//   g   in  4  per-bit generate  (a & b)
//   ci  in  1  carry into bit 0 of the group
//   c   out 4  carry into each bit of the group (c[0] = ci)
//   gg  out 1  group generate
//   gp  out 1  group propagate
// -----------------------------------------------------------------------------
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    input  logic               ci,
    output logic [GROUP_W-1:0] c,
    output logic               gg,
    output logic               gp
);

    grp_pg_t pg;

    assign c[0] = ci;
    assign c[1] = g[0]
                | (p[0] & ci);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & ci);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);

    assign pg = grp_terms(p, g);
    assign gg = pg.gg;
    assign gp = pg.gp;

endmodule

// File: rtl/cla_adder_4bit.sv
// -----------------------------------------------------------------------------
// cla_adder_4bit
// Registered carry-lookahead adder: {cout, sum} = a + b + cin, one cycle of
// latency, one operation accepted per cycle, no backpressure.
// Built from WIDTH/4 cla_group4 blocks; group carries are chained with
// cgrp[k+1] = GG[k] | GP[k] & cgrp[k].
// Parameters:
//   WIDTH  operand width; must be a multiple of 4 and >= 4
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset (priority over in_valid)
//   in_valid   in   1      operands valid this cycle
//   a, b       in   WIDTH  unsigned operands
//   cin        in   1      carry-in
//   out_valid  out  1      outputs hold the result of last edge's operands
//   sum        out  WIDTH  registered sum
//   cout       out  1      registered carry out of bit WIDTH-1
//   ovf        out  1      registered signed overflow (only with CLA_OVF_EN)
// Configuration macro: CLA_OVF_EN adds the ovf output and its register.
// -----------------------------------------------------------------------------
module cla_adder_4bit
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
`ifdef CLA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NGRP = WIDTH / GROUP_W;

    generate
        if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
            $error("cla_adder_4bit: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [NGRP-1:0]  grp_gg;
    logic [NGRP-1:0]  grp_gp;
    logic [NGRP:0]    cgrp;

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;

    assign p       = a ^ b;
    assign g       = a & b;
    assign cgrp[0] = cin;

    generate
        for (genvar k = 0; k < NGRP; k++) begin : g_grp
            cla_group4 u_grp (
                .p  (p[k*GROUP_W +: GROUP_W]),
                .g  (g[k*GROUP_W +: GROUP_W]),
                .ci (cgrp[k]),
                .c  (c[k*GROUP_W +: GROUP_W]),
                .gg (grp_gg[k]),
                .gp (grp_gp[k])
            );
            assign cgrp[k+1] = grp_gg[k] | (grp_gp[k] & cgrp[k]);
        end
    endgenerate

    assign sum_d  = p ^ c;
    assign cout_d = cgrp[NGRP];

    // Output register stage: data registers are also cleared by rst so the
    // outputs are never X after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

`ifdef CLA_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = cgrp[NGRP] ^ c[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder_4bit.sv
module tb_cla_adder_4bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // WIDTH=4 instance
    logic       in_valid4, cin4, out_valid4, cout4;
    logic [3:0] a4, b4, sum4;
    // WIDTH=8 instance
    logic       in_valid8, cin8, out_valid8, cout8;
    logic [7:0] a8, b8, sum8;
`ifdef CLA_OVF_EN
    logic       ovf4, ovf8;
`endif

    cla_adder_4bit #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .sum       (sum4),
`ifdef CLA_OVF_EN
        .ovf       (ovf4),
`endif
        .cout      (cout4)
    );

    cla_adder_4bit #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .sum       (sum8),
`ifdef CLA_OVF_EN
        .ovf       (ovf8),
`endif
        .cout      (cout8)
    );

    typedef struct {
        logic       vld;
        logic [3:0] s;
        logic       c;
        logic       o;
    } exp4_t;

    typedef struct {
        logic       vld;
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp8_t;

    exp4_t q4[$];
    exp8_t q8[$];
    exp4_t m4;
    exp8_t m8;

    int n_vec = 0;
    int n_err = 0;

    // Expected state after each edge is pushed by the driver; the monitor
    // pops it half a cycle later and compares the DUT outputs.
    always @(negedge clk) begin
        if (q4.size() > 0) begin
            exp4_t e;
            logic  ok;
            e  = q4.pop_front();
            ok = (out_valid4 === e.vld) && (sum4 === e.s) && (cout4 === e.c);
`ifdef CLA_OVF_EN
            ok = ok && (ovf4 === e.o);
`endif
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL w4 vec%0d: got vld=%b cout=%b sum=%h, expected vld=%b cout=%b sum=%h ovf=%b",
                         n_vec, out_valid4, cout4, sum4, e.vld, e.c, e.s, e.o);
            end
        end
        if (q8.size() > 0) begin
            exp8_t e;
            logic  ok;
            e  = q8.pop_front();
            ok = (out_valid8 === e.vld) && (sum8 === e.s) && (cout8 === e.c);
`ifdef CLA_OVF_EN
            ok = ok && (ovf8 === e.o);
`endif
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL w8 vec%0d: got vld=%b cout=%b sum=%h, expected vld=%b cout=%b sum=%h ovf=%b",
                         n_vec, out_valid8, cout8, sum8, e.vld, e.c, e.s, e.o);
            end
        end
    end

    // One clock of WIDTH=4 stimulus; es/ec/eo are the result expected when
    // the operation is accepted. Reset and in_valid=0 are modelled here.
    task automatic step4(input logic r, input logic v, input logic [3:0] ia, input logic [3:0] ib,
                         input logic ic, input logic [3:0] es, input logic ec, input logic eo);
        rst       = r;
        in_valid8 = 1'b0;
        in_valid4 = v;
        a4        = ia;
        b4        = ib;
        cin4      = ic;
        @(posedge clk);
        if (r) begin
            m4.vld = 1'b0; m4.s = 4'h0; m4.c = 1'b0; m4.o = 1'b0;
        end else if (v) begin
            m4.vld = 1'b1; m4.s = es; m4.c = ec; m4.o = eo;
        end else begin
            m4.vld = 1'b0;
        end
        q4.push_back(m4);
        #1;
    endtask

    task automatic step8(input logic r, input logic v, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ic, input logic [7:0] es, input logic ec, input logic eo);
        rst       = r;
        in_valid4 = 1'b0;
        in_valid8 = v;
        a8        = ia;
        b8        = ib;
        cin8      = ic;
        @(posedge clk);
        if (r) begin
            m8.vld = 1'b0; m8.s = 8'h00; m8.c = 1'b0; m8.o = 1'b0;
        end else if (v) begin
            m8.vld = 1'b1; m8.s = es; m8.c = ec; m8.o = eo;
        end else begin
            m8.vld = 1'b0;
        end
        q8.push_back(m8);
        #1;
    endtask

    initial begin
        logic [4:0] s5;
        logic [3:0] ta, tb;
        logic       eo;

        rst = 1'b1; in_valid4 = 1'b0; in_valid8 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        @(posedge clk);
        #1;

        // Reset wins over a valid operation: F+F discarded.
        step4(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0);
        step8(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Exhaustive WIDTH=4 sweep, valid every cycle.
        for (int ci = 0; ci < 2; ci++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    s5 = 5'(ia + ib + ci);
                    ta = 4'(ia);
                    tb = 4'(ib);
                    eo = (ta[3] == tb[3]) && (s5[3] != ta[3]);
                    step4(1'b0, 1'b1, ta, tb, 1'(ci), s5[3:0], s5[4], eo);
                end
            end
        end

        // Carry chain corners.
        step4(1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0);
        step4(1'b0, 1'b1, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
        step4(1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);

        // Hold: 3+4 then idle with changing operands.
        step4(1'b0, 1'b1, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0);
        step4(1'b0, 1'b0, 4'hA, 4'h9, 1'b1, 4'h4, 1'b1, 1'b1);
        step4(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);

        // Mid-stream reset, then resume with 1-cycle latency.
        step4(1'b0, 1'b1, 4'h1, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0);
        step4(1'b1, 1'b1, 4'h5, 4'h5, 1'b0, 4'hA, 1'b0, 1'b1);
        step4(1'b0, 1'b1, 4'h2, 4'h2, 1'b1, 4'h5, 1'b0, 1'b0);
        step4(1'b0, 1'b1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);

        // WIDTH=8 cross-group carries.
        step8(1'b0, 1'b1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        step8(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        step8(1'b0, 1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        step8(1'b0, 1'b1, 8'h88, 8'h88, 1'b1, 8'h11, 1'b1, 1'b1);
        step8(1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        in_valid4 = 1'b0;
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (q4.size() != 0 || q8.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d entries left, expected 0/0", q4.size(), q8.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
